// File: rtl/fill_pkg.sv
// ---------------------------------------------------------------------------
// fill_pkg
// Shared definitions for the fill-command path. The arbiter that writes the
// fill-command FIFO and the display controller that reads it both import
// this package, so the command layout is defined in exactly one place.
//   CMD_WIDTH  : width of one packed fill command
//   MAX_REQ    : largest supported number of requesters on the arbiter
//   fill_cmd_t : {size[2:0], vectors[2:0]}
// ---------------------------------------------------------------------------
package fill_pkg;

  localparam int CMD_WIDTH = 6;
  localparam int MAX_REQ   = 8;

  typedef struct packed {
    logic [2:0] size;
    logic [2:0] vectors;
  } fill_cmd_t;

  // A command that carries no vectors draws nothing.
  function automatic logic is_empty_cmd(input fill_cmd_t cmd);
    return cmd.vectors == 3'd0;
  endfunction

endpackage

// File: rtl/fill_cmd_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority pick. Searches req starting at ptr and
// wrapping modulo N; the first set bit wins.
//   req : request vector, one bit per requester
//   ptr : index with the highest priority this cycle (must be < N)
//   gnt : one-hot winner, all zeros when req is empty
//   idx : binary index of the winner, 0 when req is empty
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   slot;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    for (int k = 0; k < N; k++) begin
      slot = (int'(ptr) + k) % N;
      if (!found && req[slot]) begin
        found     = 1'b1;
        gnt[slot] = 1'b1;
        idx       = IW'(slot);
      end
    end
  end

endmodule

// File: rtl/fill_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// fill_cmd_arbiter
// Shares the single write port of the fill-command dcfifo between N_REQ
// requesters. Each requester owns a one-entry slot; a round-robin pick moves
// one pending slot per cycle into a single output stage that drives the FIFO.
// The FIFO has overflow checking off, so wrreq is never raised while wrfull.
//
// Ports
//   clk        : FIFO write clock
//   reset      : synchronous, active-high
//   req_valid  : requester i offers a command
//   req_cmd    : command i in slice [i*WIDTH +: WIDTH], {size, vectors}
//   req_ready  : slot i is empty
//   wrfull     : dcfifo write-side full flag
//   wrreq      : FIFO write strobe
//   data       : FIFO write data (the output stage, at all times)
//   grant      : one-cycle one-hot pulse, slot i moved to the output stage
//   busy       : a slot is pending or the output stage holds a command
//
// Build option
//   FILL_ARB_DROP_ZERO_EN : commands with vectors==0 are granted (grant
//   pulses, pointer advances) but never reach the FIFO.
// ---------------------------------------------------------------------------
module fill_cmd_arbiter
  import fill_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = CMD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_cmd,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   wrfull,
  output logic                   wrreq,
  output logic [WIDTH-1:0]       data,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy
);

  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0] pend_q, pend_d;
  fill_cmd_t        cmd_q [N_REQ];
  fill_cmd_t        cmd_d [N_REQ];
  logic             out_valid_q, out_valid_d;
  fill_cmd_t        out_cmd_q, out_cmd_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [N_REQ-1:0] accept;
  logic             out_ld;
  logic             keep;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;

  rr_pick #(
    .N  (N_REQ),
    .IW (PW)
  ) u_pick (
    .req (pend_q),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Outputs. wrfull is used combinationally, matching dcfifo write timing.
  always_comb begin
    req_ready = ~pend_q;
    wrreq     = out_valid_q & ~wrfull & ~reset;
    data      = out_cmd_q;
    grant     = grant_q;
    busy      = (|pend_q) | out_valid_q;
  end

  // The output stage can take a winner when it is empty or draining now.
  always_comb begin
    accept = req_valid & ~pend_q;
    out_ld = (|pend_q) & (~out_valid_q | wrreq);
`ifdef FILL_ARB_DROP_ZERO_EN
    keep   = ~is_empty_cmd(cmd_q[pick_idx]);
`else
    keep   = 1'b1;
`endif
  end

  always_comb begin
    cmd_d = cmd_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) cmd_d[i] = fill_cmd_t'(req_cmd[i*WIDTH +: WIDTH]);
    end

    // A granted slot was pending, so it cannot be accepting this cycle.
    pend_d      = (pend_q | accept) & ~({N_REQ{out_ld}} & pick_gnt);
    out_valid_d = out_valid_q & ~wrreq;
    out_cmd_d   = out_cmd_q;
    grant_d     = '0;
    ptr_d       = ptr_q;
    if (out_ld) begin
      grant_d = pick_gnt;
      ptr_d   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      // A dropped command still consumes its turn but leaves the stage empty.
      if (keep) begin
        out_valid_d = 1'b1;
        out_cmd_d   = cmd_q[pick_idx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  // NOTE: slot payloads are not reset; they are only read while pend is
  // set, and pend is cleared by reset.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

endmodule
